attention_av_scheduler: RTL and testbench

//  Sequences one shared A*V multiply-accumulate lane to compute Z[l,n,e] = sum_l2 A[l,n,l2]*V[l2,n,e].

---
 rtl/attention_av_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_attention_av_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/attention_av_scheduler.sv
// attention_av_scheduler: drives one shared A*V MAC lane through the
// Z[l,n,e] = sum_l2 A[l,n,l2]*V[l2,n,e] loop nest. It scans the per-token
// precision codes to find the tokens that are kept, then issues one beat per
// term, with pruned tokens skipped. It then waits for every Z result before it
// reports done.
module attention_av_scheduler #(
  parameter int L = 8,
  parameter int N = 1,
  parameter int E = 8,
  localparam int AW = $clog2(L * N * ((L > E) ? L : E))
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [4*L-1:0]  token_prec,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            err,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [AW-1:0]   iss_a_addr,
  output logic [AW-1:0]   iss_v_addr,
  output logic [AW-1:0]   iss_z_addr,
  output logic [1:0]      iss_prec,
  output logic            iss_first,
  output logic            iss_last,
  output logic            iss_zero,
  input  logic            res_valid
);

  localparam int LW    = (L > 1) ? $clog2(L) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int EW    = (E > 1) ? $clog2(E) : 1;
  localparam int TOTAL = L * N * E;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_DRAIN, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [4*L-1:0]  prec_q, prec_d;
  logic [L-1:0]    keep_q, keep_d;
  logic [LW-1:0]   scan_q, scan_d;
  logic [LW-1:0]   first_q, first_d;
  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   l_q, l_d;
  logic [NW-1:0]   n_q, n_d;
  logic [EW-1:0]   e_q, e_d;
  logic [LW-1:0]   l2_q, l2_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic            err_q, err_d;
  logic            aborted_q, aborted_d;

  // Lowest set bit index of a keep vector (0 when empty).
  function automatic logic [LW-1:0] first_of(input logic [L-1:0] v);
    first_of = '0;
    for (int t = L - 1; t >= 0; t--) if (v[t]) first_of = LW'(t);
  endfunction

  // Highest set bit index of a keep vector (0 when empty).
  function automatic logic [LW-1:0] last_of(input logic [L-1:0] v);
    last_of = '0;
    for (int t = 0; t < L; t++) if (v[t]) last_of = LW'(t);
  endfunction

  // Next kept token strictly above cur.
  function automatic logic [LW-1:0] next_of(input logic [L-1:0] v, input logic [LW-1:0] cur);
    next_of = '0;
    for (int t = L - 1; t >= 0; t--) if (v[t] && (t > int'(cur))) next_of = LW'(t);
  endfunction

  logic       all_pruned;
  logic       is_first, is_last;
  logic [3:0] cur_code;

  assign all_pruned = ~|keep_q;
  assign is_first   = all_pruned | (l2_q == first_q);
  assign is_last    = all_pruned | (l2_q == last_q);
  assign cur_code   = prec_q[{l2_q, 2'b00} +: 4];

  // Next-state: job sequencing, loop-nest walk, result counting, abort override
  always_comb begin
    state_d   = state_q;
    prec_d    = prec_q;
    keep_d    = keep_q;
    scan_d    = scan_q;
    first_d   = first_q;
    last_d    = last_q;
    l_d       = l_q;
    n_d       = n_q;
    e_d       = e_q;
    l2_d      = l2_q;
    res_cnt_d = res_cnt_q;
    err_d     = err_q;
    aborted_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SCAN;
          prec_d    = token_prec;
          keep_d    = '0;
          scan_d    = '0;
          first_d   = '0;
          last_d    = '0;
          l_d       = '0;
          n_d       = '0;
          e_d       = '0;
          l2_d      = '0;
          res_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      S_SCAN: begin
        keep_d[scan_q] = (prec_q[{scan_q, 2'b00} +: 4] != 4'hF);
        if (scan_q == LW'(L - 1)) begin
          // keep_d now holds every token, so the bounds are final here
          state_d = S_ISSUE;
          first_d = first_of(keep_d);
          last_d  = last_of(keep_d);
          l2_d    = first_of(keep_d);
        end else begin
          scan_d = scan_q + LW'(1);
        end
      end
      S_ISSUE: begin
        if (iss_ready) begin
          if (is_last) begin
            l2_d = first_q;
            if (e_q == EW'(E - 1)) begin
              e_d = '0;
              if (n_q == NW'(N - 1)) begin
                n_d = '0;
                if (l_q == LW'(L - 1)) state_d = S_DRAIN;
                else                   l_d     = l_q + LW'(1);
              end else begin
                n_d = n_q + NW'(1);
              end
            end else begin
              e_d = e_q + EW'(1);
            end
          end else begin
            l2_d = next_of(keep_q, l2_q);
          end
        end
      end
      S_DRAIN: begin
        if (res_cnt_q == CW'(TOTAL)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start clears err, so a result arriving in the start cycle is ignored
    if (res_valid && !(state_q == S_IDLE && start)) begin
      if (state_q == S_IDLE || state_q == S_SCAN || res_cnt_q == CW'(TOTAL))
        err_d = 1'b1;
      else if (state_q == S_ISSUE || state_q == S_DRAIN)
        res_cnt_d = res_cnt_q + CW'(1);
    end

    // Abort overrides everything, including a handshake this cycle
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end
  end

  // State and job registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prec_q    <= '0;
      keep_q    <= '0;
      scan_q    <= '0;
      first_q   <= '0;
      last_q    <= '0;
      l_q       <= '0;
      n_q       <= '0;
      e_q       <= '0;
      l2_q      <= '0;
      res_cnt_q <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prec_q    <= prec_d;
      keep_q    <= keep_d;
      scan_q    <= scan_d;
      first_q   <= first_d;
      last_q    <= last_d;
      l_q       <= l_d;
      n_q       <= n_d;
      e_q       <= e_d;
      l2_q      <= l2_d;
      res_cnt_q <= res_cnt_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) & ~abort;
  assign aborted = aborted_q;
  assign err     = err_q;

  // Issue fields are forced to zero outside ISSUE so that idle outputs stay quiet
  always_comb begin
    iss_valid  = (state_q == S_ISSUE);
    iss_a_addr = '0;
    iss_v_addr = '0;
    iss_z_addr = '0;
    iss_prec   = 2'd0;
    iss_first  = 1'b0;
    iss_last   = 1'b0;
    iss_zero   = 1'b0;
    if (iss_valid) begin
      iss_a_addr = AW'((int'(l_q) * N + int'(n_q)) * L + int'(l2_q));
      iss_v_addr = AW'((int'(l2_q) * N + int'(n_q)) * E + int'(e_q));
      iss_z_addr = AW'((int'(l_q) * N + int'(n_q)) * E + int'(e_q));
      iss_first  = is_first;
      iss_last   = is_last;
      iss_zero   = all_pruned;
      if (all_pruned)            iss_prec = 2'd2;
      else if (cur_code == 4'h0) iss_prec = 2'd0;
      else if (cur_code == 4'h1) iss_prec = 2'd1;
      else                       iss_prec = 2'd2;
    end
  end

endmodule

// File: tb/tb_attention_av_scheduler.sv
// Randomized bench for attention_av_scheduler. The expected beat stream of each
// job is built from the loop-nest definition and then compared in order.
module tb_attention_av_scheduler;
  localparam int L     = 4;
  localparam int N     = 1;
  localparam int E     = 4;
  localparam int AW    = $clog2(L * N * ((L > E) ? L : E));
  localparam int TOTAL = L * N * E;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            iss_ready = 1'b0;
  logic            res_valid = 1'b0;
  logic [4*L-1:0]  token_prec = '0;
  logic            busy, done, aborted, err, iss_valid;
  logic [AW-1:0]   iss_a_addr, iss_v_addr, iss_z_addr;
  logic [1:0]      iss_prec;
  logic            iss_first, iss_last, iss_zero;

  attention_av_scheduler #(.L(L), .N(N), .E(E)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .token_prec(token_prec), .busy(busy), .done(done), .aborted(aborted),
    .err(err), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_a_addr(iss_a_addr), .iss_v_addr(iss_v_addr), .iss_z_addr(iss_z_addr),
    .iss_prec(iss_prec), .iss_first(iss_first), .iss_last(iss_last),
    .iss_zero(iss_zero), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_beat(input int a, input int v, input int z, input int p,
                                            input bit f, input bit la, input bit zr);
    logic [AW-1:0] ea, ev, ez;
    logic [1:0]    ep;
    ea = AW'(a); ev = AW'(v); ez = AW'(z); ep = 2'(p);
    return 32'({ea, ev, ez, ep, f, la, zr});
  endfunction

  // rmode: 0 = always ready, 1 = random ready, 2 = 1,0,1 then 3 idle cycles
  // abort_at: beat index on which to abort (-1 = never)
  task automatic run_job(input logic [4*L-1:0] codes, input int rmode, input int abort_at);
    logic [31:0] q[$];
    int          kept[$];
    bit          zero;
    int          issued, results, cyc, last_res_cyc, ab_seen, exp_beats;
    bit          fin;
    logic [5:0]  pat;
    logic [3:0]  c;
    logic [31:0] act;

    // reference: Z[l,n,e] terms over kept tokens, or a single zero term
    for (int t = 0; t < L; t++) if (codes[4*t +: 4] != 4'hF) kept.push_back(t);
    zero = (kept.size() == 0);
    if (zero) kept.push_back(0);
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int e = 0; e < E; e++)
          for (int i = 0; i < kept.size(); i++) begin
            int t, p;
            t = kept[i];
            c = codes[4*t +: 4];
            p = zero ? 2 : (c == 4'h0) ? 0 : (c == 4'h1) ? 1 : 2;
            q.push_back(pack_beat((l*N+n)*L+t, (t*N+n)*E+e, (l*N+n)*E+e, p,
                                  zero || i == 0, zero || i == kept.size()-1, zero));
          end
    exp_beats = q.size();

    @(negedge clk);
    token_prec = codes;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    token_prec = (4*L)'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_by_start", 32'(err), 32'd0);

    issued = 0; results = 0; cyc = 0; last_res_cyc = 0; ab_seen = 0; fin = 1'b0;
    pat = 6'b000101;
    while (!fin && cyc < 3000) begin
      iss_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : pat[cyc % 6];
      abort = 1'b0;
      res_valid = 1'b0;
      if (aborted) ab_seen++;
      if (done) begin
        check("done_after_all_results", 32'(results), 32'(TOTAL));
        check("beats_issued", 32'(issued), 32'(exp_beats));
        check("done_latency_ok", 32'((cyc - last_res_cyc) <= 3), 32'd1);
        check("err_clean_job", 32'(err), 32'd0);
        fin = 1'b1;
      end else if (iss_valid) begin
        if (q.size() == 0) begin
          check("extra_beat", 32'(issued + 1), 32'(exp_beats));
        end else begin
          act = 32'({iss_a_addr, iss_v_addr, iss_z_addr, iss_prec, iss_first, iss_last, iss_zero});
          check("beat", act, q[0]);
          if (iss_ready) begin
            if (issued == abort_at) begin
              abort = 1'b1;
            end else begin
              res_valid = q[0][1];
              void'(q.pop_front());
              issued++;
              if (res_valid) begin
                results++;
                last_res_cyc = cyc;
              end
            end
          end
        end
      end
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        iss_ready = 1'b0;
        check("aborted_pulse", 32'(aborted), 32'd1);
        check("abort_to_idle", 32'(busy), 32'd0);
        check("abort_no_valid", 32'(iss_valid), 32'd0);
        check("abort_beats_counted", 32'(issued), 32'(abort_at));
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("aborted_one_cycle", 32'(aborted), 32'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    iss_ready = 1'b0;
    res_valid = 1'b0;
    if (!fin) check("job_timeout_cycles", 32'(cyc), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("no_abort_pulse", 32'(ab_seen), 32'd0);
  endtask

  initial begin
    logic [4*L-1:0] rc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_iss_first", 32'(iss_first), 32'd0);
    rst_n = 1'b1;

    run_job(16'h2222, 0, -1);   // dense, all FP16
    run_job(16'h7210, 0, -1);   // prec 0,1,2,2
    run_job(16'h0F1F, 1, -1);   // tokens 1 and 3 only
    run_job(16'hFFFF, 0, -1);   // all pruned
    run_job(16'h2222, 2, -1);   // stall pattern
    run_job(16'h2222, 0, 9);    // abort on the 10th beat
    run_job(16'h2222, 0, -1);   // full job after abort

    // stray result once the job has finished
    @(negedge clk);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    check("err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);

    for (int j = 0; j < 6; j++) begin
      for (int t = 0; t < L; t++)
        rc[4*t +: 4] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      run_job(rc, $urandom_range(0, 2), -1);
    end

    // start and abort together in IDLE: start wins
    @(negedge clk);
    token_prec = 16'h2222;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_beats_abort_busy", 32'(busy), 32'd1);
    check("start_beats_abort_no_pulse", 32'(aborted), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_scan", 32'(aborted), 32'd1);

    // asynchronous reset in the middle of a job
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    iss_ready = 1'b1;
    repeat (7) @(negedge clk);
    check("midjob_valid_before_rst", 32'(iss_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(iss_valid), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    iss_ready = 1'b0;
    @(negedge clk);
    check("async_rst_no_aborted", 32'(aborted), 32'd0);
    check("async_rst_no_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
